stream_demux_1_4: RTL and testbench

//   Sequential 1:4 demultiplexer for valid/ready streams.

---
 rtl/stream_demux_pkg.sv | 13 +
 rtl/demux_skid_slot.sv | 78 +++++++
 rtl/stream_demux_1_4.sv | 40 ++++
 tb/tb_stream_demux_1_4.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and slot state encoding for the 1:4 stream demultiplexer.
package stream_demux_pkg;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } slot_state_t;

endpackage : stream_demux_pkg

// File: rtl/demux_skid_slot.sv
// Two-entry skid buffer for one output channel of the demux. The head register
// always drives the channel output; the skid register catches the beat that is
// accepted while the head is waiting on a stalled consumer.
module demux_skid_slot
   import stream_demux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         full,
   input  logic         pop_rdy,
   output logic         head_vld,
   output logic [W-1:0] head_data
);

   slot_state_t  state_q, state_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] skid_q, skid_d;
   logic         pop;

   // Status decoded from registered state only, so out_rdy never reaches in_rdy.
   assign head_vld  = (state_q != EMPTY);
   assign full      = (state_q == FULL);
   assign head_data = head_q;
   assign pop       = head_vld & pop_rdy;

   // Next-state and data movement; a push in FULL is impossible because the
   // top level withholds in_rdy, so it is simply ignored here.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               head_d  = push_data;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_d = FULL;
               skid_d  = push_data;
            end else if (pop && !push) begin
               state_d = EMPTY;
            end else if (push && pop) begin
               head_d  = push_data;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               head_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State and payload registers; reset discards any buffered beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

endmodule : demux_skid_slot

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer. Each beat is steered by in_sel into one
// of four skid slots; only a FULL destination slot holds off the input.
module stream_demux_1_4
   import stream_demux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [W-1:0]          in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic [N_CH-1:0][W-1:0] out_data,
   output logic [N_CH-1:0]       out_vld,
   input  logic [N_CH-1:0]       out_rdy
);

   logic [N_CH-1:0] push;
   logic [N_CH-1:0] full;

   // Ready depends only on the selected slot's registered full flag.
   assign in_rdy = rst_n & ~full[in_sel];

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign push[gi] = in_vld & in_rdy & (in_sel == SEL_W'(gi));

      demux_skid_slot #(.W(W)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (push[gi]),
         .push_data (in_data),
         .full      (full[gi]),
         .pop_rdy   (out_rdy[gi]),
         .head_vld  (out_vld[gi]),
         .head_data (out_data[gi])
      );
   end

endmodule : stream_demux_1_4

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: a directed vector table plus randomized traffic
// checked against per-channel capacity-2 FIFO reference queues.
module tb_stream_demux_1_4;

   localparam int W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [W-1:0]      in_data;
   logic [1:0]        in_sel;
   logic              in_vld;
   logic              in_rdy;
   logic [3:0][W-1:0] out_data;
   logic [3:0]        out_vld;
   logic [3:0]        out_rdy;

   int errors = 0;
   int checks = 0;

   // Reference: each channel is a FIFO holding at most two beats.
   logic [W-1:0] ref_q [4][2];
   int           ref_n [4];
   logic         last_vld, last_acc;

   always #5 clk = ~clk;

   stream_demux_1_4 #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .out_data (out_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy)
   );

   typedef struct {
      logic       v;
      logic [1:0] s;
      logic [3:0] d;
      logic [3:0] r;
      logic       e_rdy;
      logic [3:0] e_vld;
      logic [15:0] e_dat;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle's inputs (called just after a falling edge) and compare
   // the settled outputs against the reference queues.
   task automatic apply(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
      logic [3:0] e_vld;
      in_vld  = v;
      in_sel  = s;
      in_data = d;
      out_rdy = r;
      #1;
      for (int i = 0; i < 4; i++) e_vld[i] = (ref_n[i] > 0);
      chk("model_in_rdy", 32'(in_rdy), 32'(rst_n && ref_n[s] < 2));
      chk("model_out_vld", 32'(out_vld), 32'(e_vld));
      for (int i = 0; i < 4; i++)
         if (ref_n[i] > 0) chk("model_out_data", 32'(out_data[i]), 32'(ref_q[i][0]));
   endtask

   // Clock the DUT and advance the reference by the same handshakes.
   task automatic advance();
      logic       acc;
      logic [3:0] pops;
      acc = in_vld && (ref_n[in_sel] < 2);
      for (int i = 0; i < 4; i++) pops[i] = (ref_n[i] > 0) && out_rdy[i];
      last_vld = in_vld;
      last_acc = acc;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (pops[i]) begin
            ref_q[i][0] = ref_q[i][1];
            ref_n[i]--;
         end
      end
      if (acc) begin
         ref_q[in_sel][ref_n[in_sel]] = in_data;
         ref_n[in_sel]++;
      end
      @(negedge clk);
   endtask

   initial begin
      logic       v;
      logic [1:0] s;
      logic [3:0] d, r;
      for (int i = 0; i < 4; i++) ref_n[i] = 0;
      last_vld = 1'b0;
      last_acc = 1'b0;

      // Directed table: single beat, backpressure on ch1, isolation via ch3, drain.
      tbl[0]  = '{1'b1, 2'd2, 4'hA, 4'hF, 1'b1, 4'b0000, 16'h0000};
      tbl[1]  = '{1'b0, 2'd2, 4'h0, 4'hF, 1'b1, 4'b0100, 16'h0A00};
      tbl[2]  = '{1'b0, 2'd2, 4'h0, 4'hF, 1'b1, 4'b0000, 16'h0000};
      tbl[3]  = '{1'b1, 2'd1, 4'h5, 4'hD, 1'b1, 4'b0000, 16'h0000};
      tbl[4]  = '{1'b1, 2'd1, 4'h6, 4'hD, 1'b1, 4'b0010, 16'h0050};
      tbl[5]  = '{1'b1, 2'd1, 4'h7, 4'hD, 1'b0, 4'b0010, 16'h0050};
      tbl[6]  = '{1'b1, 2'd1, 4'h7, 4'hD, 1'b0, 4'b0010, 16'h0050};
      tbl[7]  = '{1'b1, 2'd3, 4'h9, 4'hD, 1'b1, 4'b0010, 16'h0050};
      tbl[8]  = '{1'b1, 2'd1, 4'h7, 4'hD, 1'b0, 4'b1010, 16'h9050};
      tbl[9]  = '{1'b1, 2'd3, 4'hB, 4'hD, 1'b1, 4'b0010, 16'h0050};
      tbl[10] = '{1'b1, 2'd1, 4'h7, 4'hD, 1'b0, 4'b1010, 16'hB050};
      tbl[11] = '{1'b1, 2'd1, 4'h7, 4'hF, 1'b0, 4'b0010, 16'h0050};
      tbl[12] = '{1'b1, 2'd1, 4'h7, 4'hF, 1'b1, 4'b0010, 16'h0060};
      tbl[13] = '{1'b0, 2'd1, 4'h0, 4'hF, 1'b1, 4'b0010, 16'h0070};
      tbl[14] = '{1'b0, 2'd1, 4'h0, 4'hF, 1'b1, 4'b0000, 16'h0000};

      // Reset with a valid beat presented.
      rst_n   = 1'b0;
      in_vld  = 1'b1;
      in_sel  = 2'd0;
      in_data = 4'hF;
      out_rdy = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_in_rdy", 32'(in_rdy), 32'd0);
      chk("reset_out_vld", 32'(out_vld), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      in_vld = 1'b0;
      rst_n  = 1'b1;
      #1;
      chk("release_in_rdy", 32'(in_rdy), 32'd1);
      @(negedge clk);

      for (int k = 0; k < 15; k++) begin
         apply(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].r);
         chk("vec_in_rdy", 32'(in_rdy), 32'(tbl[k].e_rdy));
         chk("vec_out_vld", 32'(out_vld), 32'(tbl[k].e_vld));
         for (int i = 0; i < 4; i++)
            if (tbl[k].e_vld[i]) chk("vec_out_data", 32'(out_data[i]), 32'(tbl[k].e_dat[i*4 +: 4]));
         $display("vec %0d: vld=%0b sel=%0d data=%0h out_rdy=%b -> in_rdy=%0b out_vld=%b",
                  k, tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].r, in_rdy, out_vld);
         advance();
      end

      // Streaming: every consumer ready, the input must never stall.
      for (int k = 0; k < 64; k++) begin
         apply(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 4'hF);
         chk("stream_in_rdy", 32'(in_rdy), 32'd1);
         $display("stream %0d: sel=%0d data=%0h in_rdy=%0b", k, in_sel, in_data, in_rdy);
         advance();
      end

      // Random traffic and backpressure; a stalled beat is held unchanged.
      for (int k = 0; k < 300; k++) begin
         if (last_vld && !last_acc) begin
            v = 1'b1;
            s = in_sel;
            d = in_data;
         end else begin
            v = 1'($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            d = 4'($urandom);
         end
         r = 4'($urandom);
         apply(v, s, d, r);
         $display("rand %0d: vld=%0b sel=%0d data=%0h out_rdy=%b in_rdy=%0b out_vld=%b",
                  k, v, s, d, r, in_rdy, out_vld);
         advance();
      end

      // Drain, then fill ch0 and reset between clock edges.
      for (int k = 0; k < 4; k++) begin
         apply(1'b0, 2'd0, 4'h0, 4'hF);
         advance();
      end
      apply(1'b1, 2'd0, 4'h3, 4'hE);
      advance();
      apply(1'b1, 2'd0, 4'h4, 4'hE);
      advance();
      apply(1'b0, 2'd0, 4'h0, 4'hE);
      chk("midrst_full_rdy", 32'(in_rdy), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_vld", 32'(out_vld), 32'd0);
      chk("midrst_in_rdy", 32'(in_rdy), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      $display("mid-reset: out_vld=%b in_rdy=%0b", out_vld, in_rdy);
      for (int i = 0; i < 4; i++) ref_n[i] = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         apply(1'b0, 2'd0, 4'h0, 4'hF);
         chk("post_rst_out_vld", 32'(out_vld), 32'd0);
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_stream_demux_1_4
